dpram_responder: RTL and testbench



---
 rtl/dpram_pkg.sv | 18 +
 rtl/dpram_read_pipe.sv | 52 +++++
 rtl/dpram_responder.sv | 115 +++++++++++
 tb/tb_dpram_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM responder.
//   - default data/address widths
//   - data_t / addr_t word types at the default widths
//   - state_t: INIT (self-clearing sweep) and READY (accepting traffic)
package dpram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;
    typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/dpram_read_pipe.sv
// Read-return pipeline: READ_LATENCY-deep shift register of {valid, data}.
// Stage 0 captures on the sampling edge, so the last stage shows the result
// exactly READ_LATENCY edges after the read was sampled.
// Ports:
//   clock, reset      - clock, async active-high reset
//   captureValid      - a read is sampled this edge
//   captureData       - word captured for that read (already write-first)
//   dataOut           - read result, holds last value while dataValid=0
//   dataValid         - dataOut carries a read result this cycle
module dpram_read_pipe
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  captureValid,
    input  logic [DATA_WIDTH-1:0] captureData,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid
);

    logic [READ_LATENCY-1:0] validPipe;
    logic [DATA_WIDTH-1:0]   dataPipe [READ_LATENCY];

    // Data stages only load behind a valid bit, so every stage (and in
    // particular the output stage) holds its last result between reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            validPipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dataPipe[i] <= '0;
            end
        end else begin
            validPipe[0] <= captureValid;
            if (captureValid) begin
                dataPipe[0] <= captureData;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                validPipe[i] <= validPipe[i-1];
                if (validPipe[i-1]) begin
                    dataPipe[i] <= dataPipe[i-1];
                end
            end
        end
    end

    assign dataOut   = dataPipe[READ_LATENCY-1];
    assign dataValid = validPipe[READ_LATENCY-1];

endmodule

// File: rtl/dpram_responder.sv
// Dual-port RAM responder: one write port and one read port per cycle,
// registered read data with a valid qualifier, and a self-clearing sweep
// after every reset.
// Ports:
//   clock, reset                     - clock, async active-high reset
//   writeEnable/dataIn/writeAddress  - write port, sampled at posedge
//   readEnable/readAddress           - read port, sampled at posedge
//   dataOut/dataValid                - read result, READ_LATENCY edges later
//   ready                            - sweep finished, traffic accepted
//
// state | meaning
// INIT  | sweeping INIT_VALUE into every location, traffic ignored
// READY | normal read/write operation until the next reset
module dpram_responder
    import dpram_pkg::*;
#(
    parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int                    ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  writeEnable,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic [ADDR_WIDTH-1:0] writeAddress,
    input  logic                  readEnable,
    input  logic [ADDR_WIDTH-1:0] readAddress,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    output logic                  ready
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : gLatencyCheck
            $error("dpram_responder: READ_LATENCY must be in 1..4");
        end
    endgenerate

    state_t                state;
    state_t                nextState;
    logic [ADDR_WIDTH-1:0] initAddr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  captureValid;
    logic [DATA_WIDTH-1:0] captureData;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        ready     = 1'b0;
        case (state)
            INIT: begin
                if (initAddr == LAST_ADDR) begin
                    nextState = READY;
                end
            end
            READY: begin
                ready = 1'b1;
            end
            default: begin
                nextState = INIT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            initAddr <= '0;
        end else if (state == INIT) begin
            initAddr <= initAddr + 1'b1;
        end
    end

    // Storage has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            mem[initAddr] <= INIT_VALUE;
        end else if (writeEnable) begin
            mem[writeAddress] <= dataIn;
        end
    end

    // Write-first on a same-address collision: bypass the incoming word.
    always_comb begin
        captureValid = (state == READY) && readEnable;
        if (writeEnable && (writeAddress == readAddress)) begin
            captureData = dataIn;
        end else begin
            captureData = mem[readAddress];
        end
    end

    dpram_read_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) uReadPipe (
        .clock        (clock),
        .reset        (reset),
        .captureValid (captureValid),
        .captureData  (captureData),
        .dataOut      (dataOut),
        .dataValid    (dataValid)
    );

endmodule

// File: tb/tb_dpram_responder.sv
// Bench for dpram_responder: two instances (READ_LATENCY 1 and 3) share one
// stimulus stream; a queue-based reference model predicts ready, dataValid
// and dataOut for both, checked on every cycle, plus literal spot checks.
module tb_dpram_responder;
    import dpram_pkg::*;

    localparam int DEPTH = 256;

    logic  clock = 1'b0;
    logic  reset;
    logic  writeEnable;
    data_t dataIn;
    addr_t writeAddress;
    logic  readEnable;
    addr_t readAddress;
    data_t dataOut1, dataOut3;
    logic  dataValid1, dataValid3, ready1, ready3;

    always #5 clock = ~clock;

    dpram_responder #(.READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .writeEnable(writeEnable), .dataIn(dataIn),
        .writeAddress(writeAddress), .readEnable(readEnable), .readAddress(readAddress),
        .dataOut(dataOut1), .dataValid(dataValid1), .ready(ready1)
    );

    dpram_responder #(.READ_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset), .writeEnable(writeEnable), .dataIn(dataIn),
        .writeAddress(writeAddress), .readEnable(readEnable), .readAddress(readAddress),
        .dataOut(dataOut3), .dataValid(dataValid3), .ready(ready3)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int    due;
        data_t data;
    } pend_t;

    data_t modelMem [DEPTH];
    pend_t q1 [$];
    pend_t q3 [$];
    int    edges = 0;
    data_t rd;
    logic  expReady = 1'b0, expValid1 = 1'b0, expValid3 = 1'b0;
    data_t expData1 = '0, expData3 = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            edges     = 0;
            q1.delete();
            q3.delete();
            expReady  = 1'b0;
            expValid1 = 1'b0;
            expValid3 = 1'b0;
            expData1  = '0;
            expData3  = '0;
        end else begin
            if (edges < DEPTH) begin
                modelMem[edges] = 8'h00;
            end else begin
                if (readEnable) begin
                    rd = (writeEnable && writeAddress == readAddress) ? dataIn : modelMem[readAddress];
                    q1.push_back('{edges + 1, rd});
                    q3.push_back('{edges + 3, rd});
                end
                if (writeEnable) begin
                    modelMem[writeAddress] = dataIn;
                end
            end
            edges = edges + 1;
            expReady = (edges >= DEPTH);
            if (q1.size() > 0 && q1[0].due == edges) begin
                expValid1 = 1'b1;
                expData1  = q1[0].data;
                void'(q1.pop_front());
            end else begin
                expValid1 = 1'b0;
            end
            if (q3.size() > 0 && q3[0].due == edges) begin
                expValid3 = 1'b1;
                expData3  = q3[0].data;
                void'(q3.pop_front());
            end else begin
                expValid3 = 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        check("ready1", {31'd0, ready1}, {31'd0, expReady});
        check("valid1", {31'd0, dataValid1}, {31'd0, expValid1});
        check("data1", {24'd0, dataOut1}, {24'd0, expData1});
        check("ready3", {31'd0, ready3}, {31'd0, expReady});
        check("valid3", {31'd0, dataValid3}, {31'd0, expValid3});
        check("data3", {24'd0, dataOut3}, {24'd0, expData3});
    endtask

    // Drive one cycle's inputs (from a negedge), pass one posedge, check.
    task automatic step(input logic we, input addr_t wa, input data_t din,
                        input logic re, input addr_t ra);
        writeEnable  = we;
        writeAddress = wa;
        dataIn       = din;
        readEnable   = re;
        readAddress  = ra;
        @(negedge clock);
        checkModel();
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    // Release reset, run INIT with some traffic, and pin ready timing.
    task automatic runInit(input logic withTraffic);
        reset = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (withTraffic && k == 5)
                step(1'b1, 8'h10, 8'hAA, 1'b0, 8'h00);
            else if (withTraffic && (k % 7) == 0)
                step(1'b0, 8'h00, 8'h00, 1'b1, 8'h10);
            else
                idle();
            if (k == DEPTH - 1) begin
                check("init_ready1_at255", {31'd0, ready1}, 32'd0);
                check("init_ready3_at255", {31'd0, ready3}, 32'd0);
            end
        end
        check("init_ready1_at256", {31'd0, ready1}, 32'd1);
        check("init_ready3_at256", {31'd0, ready3}, 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        writeEnable  = 1'b0;
        writeAddress = '0;
        dataIn       = '0;
        readEnable   = 1'b0;
        readAddress  = '0;
        @(negedge clock);
        check("rst_ready", {31'd0, ready1}, 32'd0);
        check("rst_valid", {31'd0, dataValid1}, 32'd0);
        check("rst_data", {24'd0, dataOut3}, 32'd0);
        idle();

        // INIT sweep with traffic that must be ignored
        runInit(1'b1);

        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h37);
        check("read37_valid", {31'd0, dataValid1}, 32'd1);
        check("read37_data", {24'd0, dataOut1}, 32'h00);
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h10);
        check("init_write_ignored", {24'd0, dataOut1}, 32'h00);
        repeat (3) idle();

        // latency 1 vs 3
        step(1'b1, 8'h20, 8'h5C, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h20);
        check("lat1_valid", {31'd0, dataValid1}, 32'd1);
        check("lat1_data", {24'd0, dataOut1}, 32'h5C);
        check("lat3_notyet1", {31'd0, dataValid3}, 32'd0);
        idle();
        check("lat1_hold_valid", {31'd0, dataValid1}, 32'd0);
        check("lat1_hold_data", {24'd0, dataOut1}, 32'h5C);
        check("lat3_notyet2", {31'd0, dataValid3}, 32'd0);
        idle();
        check("lat3_valid", {31'd0, dataValid3}, 32'd1);
        check("lat3_data", {24'd0, dataOut3}, 32'h5C);
        idle();

        // collision, write-first
        step(1'b1, 8'h44, 8'h11, 1'b0, 8'h00);
        step(1'b1, 8'h44, 8'h9E, 1'b1, 8'h44);
        check("collide_data", {24'd0, dataOut1}, 32'h9E);
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h44);
        check("after_collide_data", {24'd0, dataOut1}, 32'h9E);
        repeat (3) idle();

        // streaming reads with a concurrent write behind the 0x03 read
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 8'(i + 8'h80), 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(i == 4, 8'h03, 8'hFF, 1'b1, 8'(i));
            check("stream_valid", {31'd0, dataValid1}, 32'd1);
            check("stream_data", {24'd0, dataOut1}, 32'(8'h80 + i));
        end
        repeat (3) idle();
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h03);
        check("stream_late_write", {24'd0, dataOut1}, 32'hFF);
        repeat (3) idle();

        // randomized traffic on a narrow address range to force collisions
        for (int n = 0; n < 1500; n++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));
        end
        repeat (3) idle();

        // reset mid-stream with reads in flight on the latency-3 instance
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h01);
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h02);
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h03);
        readEnable = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midrst_valid3", {31'd0, dataValid3}, 32'd0);
        check("midrst_ready3", {31'd0, ready3}, 32'd0);
        check("midrst_data3", {24'd0, dataOut3}, 32'd0);
        check("midrst_ready1", {31'd0, ready1}, 32'd0);
        @(negedge clock);
        checkModel();
        idle();
        runInit(1'b1);
        repeat (4) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
